linebuf_ctrl: RTL

LINEBUF_CTRL -- requirements
Module: linebuf_ctrl

---
 rtl/linebuf_ctrl_if.sv | 37 +++
 rtl/linebuf_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/linebuf_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : linebuf_ctrl_if
//  Description : Frame request, pixel stream and line-buffer port bundle
//                for the line-buffer sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface linebuf_ctrl_if #(
    parameter int BSIZE  = 5,
    parameter int FSIZE  = 3,
    parameter int DWIDTH = 16
);
    logic                        req;
    logic [BSIZE:0]              img_size;
    logic                        in_valid;
    logic signed [DWIDTH-1:0]    in_data;
    logic                        in_ready;
    logic [FSIZE-1:0]            buf_we;
    logic [BSIZE-1:0]            buf_addr;
    logic [DWIDTH-1:0]           buf_wdata;
    logic                        win_valid;
    logic [$clog2(FSIZE)-1:0]    win_top;
    logic                        ack;

    // Frame source / pixel producer side
    modport master (
        output req, img_size, in_valid, in_data,
        input  in_ready, buf_we, buf_addr, buf_wdata, win_valid, win_top, ack
    );

    // Sequencer side
    modport slave (
        input  req, img_size, in_valid, in_data,
        output in_ready, buf_we, buf_addr, buf_wdata, win_valid, win_top, ack
    );
endinterface
`default_nettype wire

// File: rtl/linebuf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : linebuf_ctrl
//  Description : Sequences a square frame into FSIZE rotating line buffers,
//                flagging each buffered column once FSIZE-1 rows are stored.
//  Revision    : 1.0  initial release
// ============================================================================
module linebuf_ctrl #(
    parameter int BSIZE  = 5,
    parameter int FSIZE  = 3,
    parameter int DWIDTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    linebuf_ctrl_if.slave   bus
);
    localparam int               c_PW         = $clog2(FSIZE);
    localparam logic [c_PW-1:0]  c_PTR_LAST   = c_PW'(FSIZE - 1);
    localparam logic [BSIZE:0]   c_FILL_LAST  = (BSIZE+1)'(FSIZE - 2);
    localparam logic [BSIZE:0]   c_MIN_SIZE   = (BSIZE+1)'(FSIZE);
    localparam logic [BSIZE:0]   c_MAX_SIZE   = (BSIZE+1)'(2**BSIZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [BSIZE:0]     r_size;
    logic [BSIZE:0]     r_col;
    logic [BSIZE:0]     r_row;
    logic [c_PW-1:0]    r_wr_ptr;
    logic [BSIZE-1:0]   r_addr;
    logic               r_win_valid;
    logic [c_PW-1:0]    r_win_top;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_wrap;
    logic [BSIZE:0]     w_last_col;
    logic [c_PW-1:0]    w_ptr_next;
    logic               w_ack;

    // Ready depends on state only, so accept never loops back through in_valid
    assign w_in_ready = (r_state == S_FILL) || (r_state == S_STREAM);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last_col = r_size - 1'b1;
    assign w_wrap     = w_accept && (r_col == w_last_col);
    assign w_ptr_next = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and frame-complete pulse
    always_comb begin
        w_state_next = r_state;
        w_ack        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    // Frames too small for the kernel or too wide for the
                    // buffers are acknowledged without taking any pixels
                    if ((bus.img_size < c_MIN_SIZE) || (bus.img_size > c_MAX_SIZE)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (w_wrap && (r_row == c_FILL_LAST)) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_wrap && (r_row == w_last_col)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_ack        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Column/row/buffer-pointer counters and the registered window flag,
    // which lines up with the one-cycle read latency of the line buffers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_size      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_wr_ptr    <= '0;
            r_addr      <= '0;
            r_win_valid <= 1'b0;
            r_win_top   <= '0;
        end else begin
            if ((r_state == S_IDLE) && bus.req) begin
                r_size   <= bus.img_size;
                r_col    <= '0;
                r_row    <= '0;
                r_wr_ptr <= '0;
            end else if (w_accept) begin
                r_addr <= r_col[BSIZE-1:0];
                if (w_wrap) begin
                    r_col    <= '0;
                    r_row    <= r_row + 1'b1;
                    r_wr_ptr <= w_ptr_next;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            r_win_valid <= w_accept && (r_state == S_STREAM);
            // The buffer after the one being written holds the oldest row
            if (w_accept && (r_state == S_STREAM)) begin
                r_win_top <= w_ptr_next;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.buf_we    = w_accept ? (FSIZE'(1) << r_wr_ptr) : '0;
    assign bus.buf_addr  = w_accept ? r_col[BSIZE-1:0] : r_addr;
    assign bus.buf_wdata = w_accept ? bus.in_data : '0;
    assign bus.win_valid = r_win_valid;
    assign bus.win_top   = r_win_top;
    assign bus.ack       = w_ack;

endmodule
`default_nettype wire
